// File: rtl/ram_arbiter_if.sv
// Bundle of the fetch, execute and memory-controller signals around the arbiter.
// The slave view belongs to the arbiter. The master view belongs to the
// surrounding pipeline and memory environment.
interface ram_arbiter_if;
    // fetch requester
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] i_rdata;
    logic        i_ram_busy;
    // execute requester
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_en;
    logic [31:0] d_rdata;
    logic        d_ram_busy;
    // memory controller
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byte_en;
    logic [31:0] m_rdata;
    logic        m_busy;

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, d_wdata, d_byte_en, m_rdata, m_busy,
        output i_rdata, i_ram_busy, d_rdata, d_ram_busy,
               m_ren, m_wen, m_addr, m_wdata, m_byte_en
    );

    modport master (
        output iren, iaddr, dren, dwen, daddr, d_wdata, d_byte_en, m_rdata, m_busy,
        input  i_rdata, i_ram_busy, d_rdata, d_ram_busy,
               m_ren, m_wen, m_addr, m_wdata, m_byte_en
    );
endinterface

// File: rtl/ram_arbiter.sv
// Arbiter for the single-ported memory bus shared by fetch (I) and execute (D).
// Data wins ties. A saturating streak counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants made while a fetch was waiting.
// Every completion returns to IDLE for one cycle. This bubble stops a held
// request from being granted a second time.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;

    logic        d_req;
    logic        forced_i;
    logic        i_done;
    logic        d_done;

    logic        m_ren_d, m_wen_d;
    logic [31:0] m_addr_d, m_wdata_d;
    logic [3:0]  m_byte_en_d;

    assign d_req    = bus.dren | bus.dwen;
    assign forced_i = bus.iren & d_req & (streak_q == LIMIT);

    // A transaction completes when the memory is no longer busy.
    // While reset is asserted, no completion is reported.
    assign i_done = (state_q == SERVE_I) & ~bus.m_busy & nRST;
    assign d_done = (state_q == SERVE_D) & ~bus.m_busy & nRST;

    assign bus.i_ram_busy = bus.iren & ~i_done;
    assign bus.d_ram_busy = d_req & ~d_done;
    assign bus.i_rdata    = i_done ? bus.m_rdata : 32'h0;
    assign bus.d_rdata    = d_done ? bus.m_rdata : 32'h0;

    assign bus.m_ren     = m_ren_d;
    assign bus.m_wen     = m_wen_d;
    assign bus.m_addr    = m_addr_d;
    assign bus.m_wdata   = m_wdata_d;
    assign bus.m_byte_en = m_byte_en_d;

    // State and streak register; synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Grant decision, streak update and memory-bus passthrough.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        m_ren_d     = 1'b0;
        m_wen_d     = 1'b0;
        m_addr_d    = 32'h0;
        m_wdata_d   = 32'h0;
        m_byte_en_d = 4'h0;
        case (state_q)
            IDLE: begin
                if (d_req && !forced_i) begin
                    state_d = SERVE_D;
                    // Count only the data grants that keep a fetch waiting.
                    if (!bus.iren)
                        streak_d = 4'd0;
                    else if (streak_q < LIMIT)
                        streak_d = streak_q + 4'd1;
                end else if (bus.iren) begin
                    state_d  = SERVE_I;
                    streak_d = 4'd0;
                end
            end
            SERVE_I: begin
                m_ren_d     = 1'b1;
                m_addr_d    = bus.iaddr;
                m_byte_en_d = 4'hF;
                if (!bus.m_busy)
                    state_d = IDLE;
            end
            SERVE_D: begin
                // A write takes precedence over a read that arrives at the same time.
                m_wen_d     = bus.dwen;
                m_ren_d     = ~bus.dwen;
                m_addr_d    = bus.daddr;
                m_wdata_d   = bus.d_wdata;
                m_byte_en_d = bus.d_byte_en;
                if (!bus.m_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter.
// Expected memory grants are queued as stimulus is driven. They are checked
// in order when each new strobe appears on the memory bus.
module tb_ram_arbiter;
    logic CLK;
    logic nRST;

    ram_arbiter_if bus ();

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } grant_t;

    grant_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     mem_lat = 2;
    int     wait_cnt = 0;
    bit     prev_strobe = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Behavioural memory controller: read data follows the address.
    // Busy lasts mem_lat cycles from the strobe.
    assign bus.m_rdata = mem_model(bus.m_addr);
    assign bus.m_busy  = (bus.m_ren | bus.m_wen) && (wait_cnt < mem_lat);

    always @(posedge CLK) begin
        if (!nRST || !(bus.m_ren | bus.m_wen) || !bus.m_busy)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_i(input logic [31:0] a);
        grant_t g;
        g.ren = 1'b1; g.wen = 1'b0; g.addr = a; g.wdata = 32'h0; g.be = 4'hF;
        exp_q.push_back(g);
    endtask

    task automatic push_d(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        grant_t g;
        g.ren = rd & ~wr; g.wen = wr; g.addr = a; g.wdata = wd; g.be = be;
        exp_q.push_back(g);
    endtask

    // Grant monitor: a new strobe after a quiet cycle is one grant.
    always @(negedge CLK) begin
        grant_t e;
        if ((bus.m_ren | bus.m_wen) === 1'b1 && !prev_strobe) begin
            if (exp_q.size() == 0) begin
                check_val("grant_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("grant", {26'b0, bus.m_ren, bus.m_wen, bus.m_addr, bus.m_byte_en},
                                   {26'b0, e.ren, e.wen, e.addr, e.be});
                if (e.wen)
                    check_val("grant_wdata", {32'b0, bus.m_wdata}, {32'b0, e.wdata});
                $display("txn grant ren=%0b wen=%0b addr=%h be=%h t=%0t",
                         bus.m_ren, bus.m_wen, bus.m_addr, bus.m_byte_en, $time);
            end
        end
        prev_strobe <= ((bus.m_ren | bus.m_wen) === 1'b1);
    end

    task automatic i_req(input logic [31:0] a);
        int n;
        bus.iren  = 1'b1;
        bus.iaddr = a;
        for (n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (bus.i_ram_busy === 1'b0) break;
        end
        check_val("i_done_in_time", 64'(n < 200), 64'd1);
        check_val("i_rdata", {32'b0, bus.i_rdata}, {32'b0, mem_model(a)});
        $display("txn fetch addr=%h rdata=%h t=%0t", a, bus.i_rdata, $time);
        @(posedge CLK); #1;
    endtask

    task automatic i_idle();
        bus.iren = 1'b0;
    endtask

    task automatic d_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        int n;
        bus.dren = rd; bus.dwen = wr; bus.daddr = a; bus.d_wdata = wd; bus.d_byte_en = be;
        for (n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (bus.d_ram_busy === 1'b0) break;
        end
        check_val("d_done_in_time", 64'(n < 200), 64'd1);
        if (rd && !wr)
            check_val("d_rdata", {32'b0, bus.d_rdata}, {32'b0, mem_model(a)});
        $display("txn data rd=%0b wr=%0b addr=%h rdata=%h t=%0t", rd, wr, a, bus.d_rdata, $time);
        @(posedge CLK); #1;
    endtask

    task automatic d_idle();
        bus.dren = 1'b0; bus.dwen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        bus.iren = 1'b1; bus.iaddr = 32'h100;
        bus.dren = 1'b0; bus.dwen = 1'b0; bus.daddr = 32'h0;
        bus.d_wdata = 32'h0; bus.d_byte_en = 4'h0;
        mem_lat = 2;

        // Reset held with a fetch pending.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_m_ren", 64'(bus.m_ren), 64'd0);
        check_val("rst_m_wen", 64'(bus.m_wen), 64'd0);
        check_val("rst_m_addr", {32'b0, bus.m_addr}, 64'd0);
        check_val("rst_m_be", 64'(bus.m_byte_en), 64'd0);
        check_val("rst_i_busy", 64'(bus.i_ram_busy), 64'd1);
        check_val("rst_i_rdata", {32'b0, bus.i_rdata}, 64'd0);
        check_val("rst_d_busy", 64'(bus.d_ram_busy), 64'd0);

        // Fetch with two busy cycles: strobe at N+1, completion at N+3.
        @(posedge CLK); #1;
        nRST = 1'b1;
        push_i(32'h100);
        @(negedge CLK);
        check_val("f_n_m_ren", 64'(bus.m_ren), 64'd0);
        check_val("f_n_busy", 64'(bus.i_ram_busy), 64'd1);
        @(negedge CLK);
        check_val("f_n1_m_ren", 64'(bus.m_ren), 64'd1);
        check_val("f_n1_busy", 64'(bus.i_ram_busy), 64'd1);
        @(negedge CLK);
        check_val("f_n2_busy", 64'(bus.i_ram_busy), 64'd1);
        @(negedge CLK);
        check_val("f_n3_busy", 64'(bus.i_ram_busy), 64'd0);
        check_val("f_n3_rdata", {32'b0, bus.i_rdata}, {32'b0, mem_model(32'h100)});
        @(posedge CLK); #1;
        i_idle();
        @(negedge CLK);
        check_val("f_bubble_m_ren", 64'(bus.m_ren), 64'd0);
        check_val("f_bubble_busy", 64'(bus.i_ram_busy), 64'd0);
        @(posedge CLK); #1;

        // Tie: the data write wins, then a bubble, then the fetch.
        mem_lat = 1;
        push_d(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011);
        push_i(32'h100);
        fork
            begin d_req(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011); d_idle(); end
            begin i_req(32'h100); i_idle(); end
        join
        repeat (2) @(posedge CLK); #1;

        // Starvation bound: four data grants, then the forced fetch, then data again.
        mem_lat = 0;
        for (int k = 0; k < 4; k++) push_d(1'b1, 1'b0, 32'h300 + 32'(k * 4), 32'h0, 4'hF);
        push_i(32'h104);
        push_d(1'b1, 1'b0, 32'h310, 32'h0, 4'hF);
        fork
            begin
                for (int k = 0; k < 5; k++) d_req(1'b1, 1'b0, 32'h300 + 32'(k * 4), 32'h0, 4'hF);
                d_idle();
            end
            begin i_req(32'h104); i_idle(); end
        join
        repeat (2) @(posedge CLK); #1;

        // Single-cycle data read: busy is low only at N+1, and high again in the bubble.
        mem_lat = 0;
        bus.dren = 1'b1; bus.daddr = 32'h40; bus.d_byte_en = 4'hF;
        push_d(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        push_d(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        @(negedge CLK);
        check_val("d1_n_busy", 64'(bus.d_ram_busy), 64'd1);
        @(negedge CLK);
        check_val("d1_n1_busy", 64'(bus.d_ram_busy), 64'd0);
        check_val("d1_n1_rdata", {32'b0, bus.d_rdata}, {32'b0, mem_model(32'h40)});
        @(negedge CLK);
        check_val("d1_n2_busy", 64'(bus.d_ram_busy), 64'd1);
        check_val("d1_n2_m_ren", 64'(bus.m_ren), 64'd0);
        d_req(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        d_idle();
        repeat (2) @(posedge CLK); #1;

        // Reset during a stalled data write, then a clean restart.
        mem_lat = 1000;
        bus.dwen = 1'b1; bus.daddr = 32'h500; bus.d_wdata = 32'h1234_5678; bus.d_byte_en = 4'hF;
        push_d(1'b0, 1'b1, 32'h500, 32'h1234_5678, 4'hF);
        @(negedge CLK);
        check_val("r_n_m_wen", 64'(bus.m_wen), 64'd0);
        @(negedge CLK);
        check_val("r_n1_m_wen", 64'(bus.m_wen), 64'd1);
        check_val("r_n1_busy", 64'(bus.d_ram_busy), 64'd1);
        @(posedge CLK); #1;
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_val("r_after_m_wen", 64'(bus.m_wen), 64'd0);
        check_val("r_after_m_ren", 64'(bus.m_ren), 64'd0);
        check_val("r_after_m_addr", {32'b0, bus.m_addr}, 64'd0);
        check_val("r_after_d_busy", 64'(bus.d_ram_busy), 64'd1);
        check_val("r_after_d_rdata", {32'b0, bus.d_rdata}, 64'd0);
        mem_lat = 1;
        push_d(1'b0, 1'b1, 32'h500, 32'h1234_5678, 4'hF);
        @(posedge CLK); #1;
        nRST = 1'b1;
        d_req(1'b0, 1'b1, 32'h500, 32'h1234_5678, 4'hF);
        d_idle();
        repeat (3) @(posedge CLK);
        @(negedge CLK);

        check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
